// File: rtl/rx_image_store_pkg.sv
// Shared configuration for the RX image store: default widths, FIFO depth
// and the store FSM state encoding.
package ocr_bridge_config_pkg;

    localparam int PIO_DATA_WIDTH   = 128;
    localparam int IMAGE_RAM_WIDTH  = 12;
    localparam int BURST_SIZE_WIDTH = 16;
    localparam int BP_FIFO_DEPTH    = 8;

    // Store FSM encoding; kept as plain constants so older tools can consume it.
    localparam int               STATE_W    = 2;
    localparam logic [1:0]       ST_IDLE    = 2'd0;
    localparam logic [1:0]       ST_COLLECT = 2'd1;
    localparam logic [1:0]       ST_READY   = 2'd2;

endpackage

// File: rtl/rx_image_store_if.sv
// Bus bundle between the upstream RX receiver / OCR core and the image store.
//
// Handshake: image_write and breakpoint_write are single-cycle valids with no
// backpressure (the store never stalls the sender; refused writes raise
// store_err). bp_rd_en pops the FIFO head only in a cycle where bp_empty is
// low; bp_rd_data always shows the head (first-word-fall-through).
interface rx_image_store_if #(
    parameter int DATA_W  = ocr_bridge_config_pkg::PIO_DATA_WIDTH,
    parameter int ADDR_W  = ocr_bridge_config_pkg::IMAGE_RAM_WIDTH,
    parameter int BURST_W = ocr_bridge_config_pkg::BURST_SIZE_WIDTH
) ();

    logic                Clear_buff;
    logic                image_write;
    logic                breakpoint_write;
    logic [DATA_W-1:0]   RX_data_out;
    logic [ADDR_W-1:0]   addr_rx_out;
    logic                RX_done;
    logic                frame_ack;
    logic                bp_rd_en;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   bp_rd_data;
    logic                bp_empty;
    logic                bp_full;
    logic                frame_ready;
    logic [BURST_W-1:0]  frame_bursts;
    logic                store_err;
    logic [1:0]          dbg_state;

    modport master (
        output Clear_buff, image_write, breakpoint_write, RX_data_out,
               addr_rx_out, RX_done, frame_ack, bp_rd_en,
        input  ram_we, ram_addr, ram_wdata, bp_rd_data, bp_empty, bp_full,
               frame_ready, frame_bursts, store_err, dbg_state
    );

    modport slave (
        input  Clear_buff, image_write, breakpoint_write, RX_data_out,
               addr_rx_out, RX_done, frame_ack, bp_rd_en,
        output ram_we, ram_addr, ram_wdata, bp_rd_data, bp_empty, bp_full,
               frame_ready, frame_bursts, store_err, dbg_state
    );

endinterface

// File: rtl/rx_image_store_bp_fifo.sv
// Breakpoint FIFO: synchronous, first-word-fall-through, power-of-two depth.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module bp_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o
);
    import ocr_bridge_config_pkg::*;

    localparam int         PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             pop_ok;
    logic             push_ok;

    // Accept/refuse decisions and next pointer/count values.
    always_comb begin
        pop_ok     = pop_i && !clr_i && !empty_o;
        push_ok    = push_i && !clr_i && (!full_o || pop_ok);
        overflow_o = push_i && !clr_i && full_o && !pop_ok;
        wr_d       = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d       = pop_ok  ? rd_q + 1'b1 : rd_q;
        cnt_d      = cnt_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);

endmodule

// File: rtl/rx_image_store.sv
// RX image store: writes image bursts to the image RAM (one registered cycle
// late), buffers breakpoint bursts in a FIFO and tracks frame completion.
module rx_image_store #(
    parameter int PIO_DATA_WIDTH   = ocr_bridge_config_pkg::PIO_DATA_WIDTH,
    parameter int IMAGE_RAM_WIDTH  = ocr_bridge_config_pkg::IMAGE_RAM_WIDTH,
    parameter int BURST_SIZE_WIDTH = ocr_bridge_config_pkg::BURST_SIZE_WIDTH,
    parameter int BP_FIFO_DEPTH    = ocr_bridge_config_pkg::BP_FIFO_DEPTH
) (
    input  logic              clk_in,
    input  logic              rst,
    rx_image_store_if.slave   bus
);
    import ocr_bridge_config_pkg::*;

    logic [1:0]                  state_q, state_d;
    logic                        ram_we_q;
    logic [IMAGE_RAM_WIDTH-1:0]  ram_addr_q;
    logic [PIO_DATA_WIDTH-1:0]   ram_wdata_q;
    logic [BURST_SIZE_WIDTH-1:0] bursts_q, bursts_d;
    logic                        err_q, err_d;

    logic write_any;
    logic accepting;
    logic img_ok;
    logic bp_push;
    logic fifo_ovf;

    // Frame FSM; Clear_buff returns to IDLE from anywhere, RX_done beats frame_ack.
    always_comb begin
        state_d = state_q;
        if (bus.Clear_buff) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.RX_done)    state_d = ST_READY;
                    else if (write_any) state_d = ST_COLLECT;
                end
                ST_COLLECT: if (bus.RX_done)   state_d = ST_READY;
                ST_READY:   if (bus.frame_ack) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Write acceptance, burst counter and sticky error next-state.
    always_comb begin
        write_any = bus.image_write || bus.breakpoint_write;
        accepting = (state_q != ST_READY) && !bus.Clear_buff;
        img_ok    = bus.image_write && accepting;
        // An image burst wins over a breakpoint burst in the same cycle.
        bp_push   = bus.breakpoint_write && !bus.image_write && accepting;

        bursts_d = bursts_q;
        if (bus.Clear_buff) begin
            bursts_d = '0;
        end else if (state_q == ST_READY && bus.frame_ack) begin
            bursts_d = '0;
        end else if (img_ok && (bursts_q != '1)) begin
            bursts_d = bursts_q + 1'b1;
        end

        err_d = err_q;
        if (bus.Clear_buff) begin
            err_d = 1'b0;
        end else if ((write_any && state_q == ST_READY) ||
                     (bus.image_write && bus.breakpoint_write) ||
                     fifo_ovf) begin
            err_d = 1'b1;
        end
    end

    // State, registered RAM write port, counter and error flag.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            bursts_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            ram_we_q <= img_ok;
            if (img_ok) begin
                ram_addr_q  <= bus.addr_rx_out;
                ram_wdata_q <= bus.RX_data_out;
            end
            bursts_q <= bursts_d;
            err_q    <= err_d;
        end
    end

    bp_fifo #(
        .WIDTH (PIO_DATA_WIDTH),
        .DEPTH (BP_FIFO_DEPTH)
    ) u_bp_fifo (
        .clk_i      (clk_in),
        .rst_i      (rst),
        .clr_i      (bus.Clear_buff),
        .push_i     (bp_push),
        .pop_i      (bus.bp_rd_en),
        .wdata_i    (bus.RX_data_out),
        .rdata_o    (bus.bp_rd_data),
        .empty_o    (bus.bp_empty),
        .full_o     (bus.bp_full),
        .overflow_o (fifo_ovf)
    );

    assign bus.ram_we       = ram_we_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_wdata    = ram_wdata_q;
    assign bus.frame_ready  = (state_q == ST_READY);
    assign bus.frame_bursts = bursts_q;
    assign bus.store_err    = err_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_rx_image_store.sv
// Directed bench for rx_image_store: RAM writes are checked by a scoreboard
// queue ({expected cycle, addr, data}); breakpoint data by a model FIFO queue.
module tb_rx_image_store;
    import ocr_bridge_config_pkg::*;

    localparam int DW = PIO_DATA_WIDTH;
    localparam int AW = IMAGE_RAM_WIDTH;
    localparam int BW = BURST_SIZE_WIDTH;
    localparam int EW = 32 + AW + DW;
    localparam logic [DW-1:0] IMG_DATA = 128'hDEADBEEFCAFEBABE_0123456789ABCDEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] bp_q[$];
    logic [EW-1:0] mon_e;

    rx_image_store_if bus ();

    rx_image_store dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after a rising edge and are
    // sampled at the next one; tick() returns just after that sampling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Clear_buff       = 1'b0;
        bus.image_write      = 1'b0;
        bus.breakpoint_write = 1'b0;
        bus.RX_data_out      = '0;
        bus.addr_rx_out      = '0;
        bus.RX_done          = 1'b0;
        bus.frame_ack        = 1'b0;
        bus.bp_rd_en         = 1'b0;
    endtask

    task automatic img(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.image_write = 1'b1;
        bus.addr_rx_out = a;
        bus.RX_data_out = d;
        exp_q.push_back({32'(cyc + 1), a, d});
        tick();
        bus.image_write = 1'b0;
    endtask

    task automatic bp_push(input logic [DW-1:0] d, input bit accepted);
        bus.breakpoint_write = 1'b1;
        bus.RX_data_out      = d;
        if (accepted) bp_q.push_back(d);
        tick();
        bus.breakpoint_write = 1'b0;
    endtask

    task automatic bp_pop(input string tag);
        chk(tag, 192'(bus.bp_rd_data), 192'(bp_q.pop_front()));
        bus.bp_rd_en = 1'b1;
        tick();
        bus.bp_rd_en = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.Clear_buff = 1'b1;
        tick();
        bus.Clear_buff = 1'b0;
        bp_q.delete();
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_state"},   192'(bus.dbg_state), 192'(ST_IDLE));
        chk({p, "_ram_we"},  192'(bus.ram_we), 192'd0);
        chk({p, "_addr"},    192'(bus.ram_addr), 192'd0);
        chk({p, "_wdata"},   192'(bus.ram_wdata), 192'd0);
        chk({p, "_ready"},   192'(bus.frame_ready), 192'd0);
        chk({p, "_bursts"},  192'(bus.frame_bursts), 192'd0);
        chk({p, "_empty"},   192'(bus.bp_empty), 192'd1);
        chk({p, "_full"},    192'(bus.bp_full), 192'd0);
        chk({p, "_err"},     192'(bus.store_err), 192'd0);
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: every RAM write must match the head of exp_q, including cycle.
    always @(negedge clk) begin
        if (bus.ram_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("ram_we_unexpected", 192'(bus.ram_we), 192'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ram_write", 192'({32'(cyc), bus.ram_addr, bus.ram_wdata}), 192'(mon_e));
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // 20 image bursts then RX_done
        for (int i = 0; i < 20; i++) img(AW'(i), IMG_DATA);
        chk("collect_state", 192'(bus.dbg_state), 192'(ST_COLLECT));
        bus.RX_done = 1'b1;
        tick();
        bus.RX_done = 1'b0;
        chk("ready_state", 192'(bus.dbg_state), 192'(ST_READY));
        chk("ready_flag", 192'(bus.frame_ready), 192'd1);
        chk("bursts_20", 192'(bus.frame_bursts), 192'd20);
        chk("img_queue_drained", 192'(exp_q.size()), 192'd0);

        // Image write while READY is refused
        bus.image_write = 1'b1;
        bus.addr_rx_out = AW'(5);
        bus.RX_data_out = rnd();
        tick();
        bus.image_write = 1'b0;
        chk("ready_wr_no_we", 192'(bus.ram_we), 192'd0);
        chk("ready_wr_err", 192'(bus.store_err), 192'd1);
        chk("ready_wr_bursts", 192'(bus.frame_bursts), 192'd20);
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        chk("ack_state", 192'(bus.dbg_state), 192'(ST_IDLE));
        chk("ack_ready", 192'(bus.frame_ready), 192'd0);
        chk("ack_bursts", 192'(bus.frame_bursts), 192'd0);
        chk("ack_err_sticky", 192'(bus.store_err), 192'd1);

        pulse_clear();
        chk("clear_err", 192'(bus.store_err), 192'd0);
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        chk("ack_in_idle", 192'(bus.dbg_state), 192'(ST_IDLE));

        // 9 breakpoint pushes: 8 fit, 9th overflows
        for (int i = 0; i < 8; i++) bp_push(rnd(), 1'b1);
        chk("bp_full_8", 192'(bus.bp_full), 192'd1);
        chk("bp_err_before", 192'(bus.store_err), 192'd0);
        chk("bp_state", 192'(bus.dbg_state), 192'(ST_COLLECT));
        bp_push(rnd(), 1'b0);
        chk("bp_ovf_err", 192'(bus.store_err), 192'd1);
        chk("bp_ovf_full", 192'(bus.bp_full), 192'd1);
        for (int i = 0; i < 8; i++) bp_pop("bp_pop_order");
        chk("bp_empty_after", 192'(bus.bp_empty), 192'd1);
        chk("bp_full_after", 192'(bus.bp_full), 192'd0);
        bus.bp_rd_en = 1'b1;
        tick();
        bus.bp_rd_en = 1'b0;
        chk("pop_empty_ignored", 192'(bus.bp_empty), 192'd1);

        // Image and breakpoint in the same cycle
        pulse_clear();
        bp_push(rnd(), 1'b1);
        bp_push(rnd(), 1'b1);
        bus.breakpoint_write = 1'b1;
        img(AW'(7), rnd());
        bus.breakpoint_write = 1'b0;
        chk("both_err", 192'(bus.store_err), 192'd1);
        chk("both_bursts", 192'(bus.frame_bursts), 192'd1);
        bp_pop("both_pop0");
        bp_pop("both_pop1");
        chk("both_empty", 192'(bus.bp_empty), 192'd1);

        // RX_done and frame_ack together in COLLECT
        bus.RX_done   = 1'b1;
        bus.frame_ack = 1'b1;
        tick();
        bus.RX_done   = 1'b0;
        bus.frame_ack = 1'b0;
        chk("done_beats_ack", 192'(bus.dbg_state), 192'(ST_READY));
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;

        // Push and pop together while full
        pulse_clear();
        for (int i = 0; i < 8; i++) bp_push(rnd(), 1'b1);
        chk("pp_full_pre", 192'(bus.bp_full), 192'd1);
        chk("pp_head", 192'(bus.bp_rd_data), 192'(bp_q.pop_front()));
        bus.bp_rd_en = 1'b1;
        bp_push(rnd(), 1'b1);
        bus.bp_rd_en = 1'b0;
        chk("pp_full_post", 192'(bus.bp_full), 192'd1);
        chk("pp_no_err", 192'(bus.store_err), 192'd0);
        for (int i = 0; i < 8; i++) bp_pop("pp_pop_order");
        chk("pp_empty", 192'(bus.bp_empty), 192'd1);

        // Empty frame
        pulse_clear();
        bus.RX_done = 1'b1;
        tick();
        bus.RX_done = 1'b0;
        chk("empty_frame_state", 192'(bus.dbg_state), 192'(ST_READY));
        chk("empty_frame_ready", 192'(bus.frame_ready), 192'd1);
        chk("empty_frame_bursts", 192'(bus.frame_bursts), 192'd0);
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;

        // Reset in the middle of a frame
        for (int i = 0; i < 3; i++) img(AW'(100 + i), rnd());
        bp_push(rnd(), 1'b1);
        chk("mid_bursts", 192'(bus.frame_bursts), 192'd3);
        tick();
        rst = 1'b1;
        #2;
        chk_reset("midrst");
        bp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_no_we", 192'(bus.ram_we), 192'd0);

        // Clear_buff flushes a partially filled FIFO
        for (int i = 0; i < 4; i++) bp_push(rnd(), 1'b1);
        chk("clr_pre_empty", 192'(bus.bp_empty), 192'd0);
        pulse_clear();
        chk("clr_empty", 192'(bus.bp_empty), 192'd1);
        tick();

        chk("final_queue", 192'(exp_q.size()), 192'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
